sipp_mem_arbiter: RTL

Two-port round-robin arbiter that shares the single-port SIPP memory (one address, one write enable, one read enable, continuous read) between an instruction-fetch requester (port 0) and a data-access requester (port 1). It grants at most one access per cycle. It drives the memory's address, write and read controls, and registers read data back to the winning requester one cycle later. It sits between the SIPP core's fetch/load-store units and the memory instance.

---
 rtl/sipp_pkg.sv | 19 +
 rtl/sipp_mem_arbiter_if.sv | 43 ++++
 rtl/sipp_rr_pick.sv | 24 ++
 rtl/sipp_mem_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/sipp_pkg.sv
// Shared constants and access record for the SIPP memory arbiter.
// Widths here set the default bus widths of the arbiter and its interface.
// Port indices name the fetch and data requesters.
package sipp_pkg;

  localparam int SIPP_ADDR_W = 8;
  localparam int SIPP_DATA_W = 16;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

  // One requester's access: direction, address and write payload.
  typedef struct packed {
    logic                   we;
    logic [SIPP_ADDR_W-1:0] addr;
    logic [SIPP_DATA_W-1:0] wdata;
  } sipp_acc_t;

endpackage

// File: rtl/sipp_mem_arbiter_if.sv
// Requester and memory-side signals of the SIPP memory arbiter.
// slave: the arbiter's view; master: the view of whatever drives the
// requesters and models the memory.
interface sipp_mem_arbiter_if
  import sipp_pkg::*;
#(
  parameter int ADDR_WIDTH = SIPP_ADDR_W,
  parameter int DATA_WIDTH = SIPP_DATA_W
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_wr, mem_rd, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_wr, mem_rd, mem_wdata
  );

endinterface

// File: rtl/sipp_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to prio.
// Purely combinational; the priority register lives in the caller.
// nxt_prio points at the loser of any grant, otherwise keeps prio.
module sipp_rr_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       nxt_prio
);

  // Grant selection and pointer advance.
  always_comb begin
    gnt      = 2'b00;
    nxt_prio = prio;
    if (req[0] && (!req[1] || !prio)) begin
      gnt[0]   = 1'b1;
      nxt_prio = 1'b1;
    end else if (req[1]) begin
      gnt[1]   = 1'b1;
      nxt_prio = 1'b0;
    end
  end

endmodule

// File: rtl/sipp_mem_arbiter.sv
// Round-robin share of the single-port SIPP memory between fetch and data.
// Grant is combinational (0 cycles); read data returns 1 cycle after grant.
// Back-pressure is a withheld ack only; nothing is queued.
module sipp_mem_arbiter
  import sipp_pkg::*;
#(
  parameter int ADDR_WIDTH = SIPP_ADDR_W,
  parameter int DATA_WIDTH = SIPP_DATA_W
) (
  input logic               clk,
  input logic               rst,
  sipp_mem_arbiter_if.slave bus
);

  sipp_acc_t             acc0;
  sipp_acc_t             acc1;
  sipp_acc_t             win;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  prio;
  logic                  nxt_prio;
  logic [1:0]            rd_gnt;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  assign acc0 = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
  assign acc1 = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};

  // The memory initializes itself under reset, so requests are masked out
  // entirely rather than merely not acknowledged.
  assign req = {bus.req1, bus.req0} & {2{~rst}};

  sipp_rr_pick u_pick (
    .req      (req),
    .prio     (prio),
    .gnt      (gnt),
    .nxt_prio (nxt_prio)
  );

  assign bus.ack0 = gnt[PORT_FETCH];
  assign bus.ack1 = gnt[PORT_DATA];

  // Route the winner's access onto the memory bus; idle drives all zeros.
  always_comb begin
    win = '0;
    if (gnt[PORT_FETCH]) begin
      win = acc0;
    end else if (gnt[PORT_DATA]) begin
      win = acc1;
    end
  end

  assign bus.mem_addr  = win.addr;
  assign bus.mem_wdata = win.wdata;
  assign bus.mem_wr    = (|gnt) & win.we;
  assign bus.mem_rd    = (|gnt) & ~win.we;

  assign rd_gnt = gnt & ~{bus.we1, bus.we0};

  // Priority pointer: flips to the loser after each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else begin
      prio <= nxt_prio;
    end
  end

  // Capture read data for the port that read this cycle; rdata holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rd_gnt;
      if (rd_gnt[PORT_FETCH]) begin
        rdata0_q <= bus.mem_rdata;
      end
      if (rd_gnt[PORT_DATA]) begin
        rdata1_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.rvalid0 = rvalid_q[PORT_FETCH];
  assign bus.rvalid1 = rvalid_q[PORT_DATA];
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule
